csel_sub_49bit_pipe: RTL and testbench

CSEL_SUB_49BIT_PIPE -- requirements
Module: csel_sub_49bit_pipe

---
 rtl/csel_pkg.sv | 7 +
 rtl/csel_sub_seg.sv | 12 +
 rtl/csel_sub_49bit_pipe.sv | 108 ++++++++++
 tb/tb_csel_sub_49bit_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared widths and segment boundaries for the pipelined 49-bit carry-select subtractor.
package csel_pkg;
  localparam int WIDTH      = 49;
  localparam int SEG0_MSB   = 32;
  localparam int SEG1_MSB   = 48;
  localparam int NUM_STAGES = 3;
endpackage

// File: rtl/csel_sub_seg.sv
// Purely combinational segment adder: S = A + B + cin with carry-out.
module csel_sub_seg #(
  parameter int width = 32
) (
  input  logic [width:1] A,
  input  logic [width:1] B,
  input  logic           cin,
  output logic [width:1] S,
  output logic           cout
);
  assign {cout, S} = {1'b0, A} + {1'b0, B} + {{width{1'b0}}, cin};
endmodule

// File: rtl/csel_sub_49bit_pipe.sv
// Three-stage carry-select subtractor D = A - B - bin with valid/ready flow control;
// each stage resolves one segment and hands its registered carry to the next.
module csel_sub_49bit_pipe
  import csel_pkg::*;
#(
  parameter int width = WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [width:1] A,
  input  logic [width:1] B,
  input  logic           bin,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [width:1] D,
  output logic           bout,
  output logic           out_valid,
  input  logic           out_ready
);
  localparam int W0 = SEG0_MSB;
  localparam int W1 = SEG1_MSB - SEG0_MSB;
  localparam int W2 = WIDTH - SEG1_MSB;

  if (width != WIDTH || NUM_STAGES != 3) begin : gParamCheck
    $error("csel_sub_49bit_pipe supports only width=49");
  end

  logic           s1Valid_q, s2Valid_q, s3Valid_q;
  logic           s1Advance, s2Advance, s3Advance;
  logic [width:1] bNot;

  logic [W0:1]    s1Diff_q, s1Diff_d;
  logic           s1Carry_q, s1Carry_d;
  logic [W1+W2:1] s1AHi_q, s1BnHi_q;

  logic [W0+W1:1] s2Diff_q, s2Diff_d;
  logic           s2Carry_q, s2Carry_d;
  logic [W2:1]    s2ATop_q, s2BnTop_q;

  logic [width:1] s3Diff_q, s3Diff_d;
  logic           s3Bout_q, s3Bout_d;

  logic [W0:1]    seg0Sum0, seg0Sum1;
  logic           seg0Cout0, seg0Cout1;
  logic [W1:1]    seg1Sum0, seg1Sum1;
  logic           seg1Cout0, seg1Cout1;
  logic [W2:1]    seg2Sum0, seg2Sum1;
  logic           seg2Cout0, seg2Cout1;

  assign bNot = ~B;

  // Subtraction as A + ~B + ~bin: a borrow-in of 1 selects the carry-in-0 sum.
  csel_sub_seg #(.width(W0)) uSeg0C0 (.A(A[W0:1]), .B(bNot[W0:1]), .cin(1'b0), .S(seg0Sum0), .cout(seg0Cout0));
  csel_sub_seg #(.width(W0)) uSeg0C1 (.A(A[W0:1]), .B(bNot[W0:1]), .cin(1'b1), .S(seg0Sum1), .cout(seg0Cout1));
  assign s1Diff_d  = bin ? seg0Sum0  : seg0Sum1;
  assign s1Carry_d = bin ? seg0Cout0 : seg0Cout1;

  csel_sub_seg #(.width(W1)) uSeg1C0 (.A(s1AHi_q[W1:1]), .B(s1BnHi_q[W1:1]), .cin(1'b0), .S(seg1Sum0), .cout(seg1Cout0));
  csel_sub_seg #(.width(W1)) uSeg1C1 (.A(s1AHi_q[W1:1]), .B(s1BnHi_q[W1:1]), .cin(1'b1), .S(seg1Sum1), .cout(seg1Cout1));
  assign s2Diff_d  = {(s1Carry_q ? seg1Sum1 : seg1Sum0), s1Diff_q};
  assign s2Carry_d = s1Carry_q ? seg1Cout1 : seg1Cout0;

  csel_sub_seg #(.width(W2)) uSeg2C0 (.A(s2ATop_q), .B(s2BnTop_q), .cin(1'b0), .S(seg2Sum0), .cout(seg2Cout0));
  csel_sub_seg #(.width(W2)) uSeg2C1 (.A(s2ATop_q), .B(s2BnTop_q), .cin(1'b1), .S(seg2Sum1), .cout(seg2Cout1));
  assign s3Diff_d = {(s2Carry_q ? seg2Sum1 : seg2Sum0), s2Diff_q};
  assign s3Bout_d = ~(s2Carry_q ? seg2Cout1 : seg2Cout0);

  assign s3Advance = !s3Valid_q || out_ready;
  assign s2Advance = !s2Valid_q || s3Advance;
  assign s1Advance = !s1Valid_q || s2Advance;
  assign in_ready  = rst_n && s1Advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
      s3Valid_q <= 1'b0;
    end else begin
      if (s1Advance) s1Valid_q <= in_valid;
      if (s2Advance) s2Valid_q <= s1Valid_q;
      if (s3Advance) s3Valid_q <= s2Valid_q;
    end
  end

  // Datapath registers carry no reset; outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (s1Advance && in_valid) begin
      s1Diff_q  <= s1Diff_d;
      s1Carry_q <= s1Carry_d;
      s1AHi_q   <= A[width:W0+1];
      s1BnHi_q  <= bNot[width:W0+1];
    end
    if (s2Advance && s1Valid_q) begin
      s2Diff_q  <= s2Diff_d;
      s2Carry_q <= s2Carry_d;
      s2ATop_q  <= s1AHi_q[W1+W2:W1+1];
      s2BnTop_q <= s1BnHi_q[W1+W2:W1+1];
    end
    if (s3Advance && s2Valid_q) begin
      s3Diff_q <= s3Diff_d;
      s3Bout_q <= s3Bout_d;
    end
  end

  assign out_valid = s3Valid_q;
  assign D         = s3Valid_q ? s3Diff_q : '0;
  assign bout      = s3Valid_q & s3Bout_q;
endmodule

// File: tb/tb_csel_sub_49bit_pipe.sv
// Scoreboard bench for csel_sub_49bit_pipe: expected differences are queued on accept
// and compared on retire, with directed boundary, backpressure and reset scenarios.
module tb_csel_sub_49bit_pipe;
  typedef struct packed {
    logic [49:1] d;
    logic        b;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [49:1] inA, inB;
  logic        inBin;
  logic        in_valid;
  logic        in_ready;
  logic [49:1] D;
  logic        bout;
  logic        out_valid;
  logic        out_ready;

  exp_t sb[$];
  int   totalChecks = 0;
  int   badChecks = 0;
  int   acceptCount = 0;
  int   retireCount = 0;

  csel_sub_49bit_pipe #(.width(49)) dut (
    .clk(clk), .rst_n(rst_n), .A(inA), .B(inB), .bin(inBin),
    .in_valid(in_valid), .in_ready(in_ready), .D(D), .bout(bout),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden model: plain 50-bit unsigned subtraction, borrow is the top bit.
  function automatic exp_t model(input logic [49:1] a, input logic [49:1] b, input logic bi);
    logic [49:0] r;
    exp_t e;
    r = {1'b0, a} - {1'b0, b} - {49'd0, bi};
    e.d = r[48:0];
    e.b = r[49];
    return e;
  endfunction

  function automatic logic [49:1] rand49();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[48:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Handshakes are sampled on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(inA, inB, inBin));
        acceptCount++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("D", {15'd0, D}, {15'd0, e.d});
          checkOutput("bout", {63'd0, bout}, {63'd0, e.b});
        end
        retireCount++;
      end
    end
  end

  task automatic applyStimulus(input logic [49:1] a, input logic [49:1] b, input logic bi);
    bit done;
    int waitCycles;
    done = 1'b0;
    waitCycles = 0;
    inA = a;
    inB = b;
    inBin = bi;
    in_valid = 1'b1;
    while (!done && waitCycles < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!done) checkOutput("accept_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    totalChecks++;
    badChecks++;
    $display("[TB] FAIL watchdog: got=timeout expected=finished");
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin : main
    logic [49:1] ops [5];
    logic [49:1] x;
    exp_t firstExp;
    int lat, startAcc, startRet, k;
    bit acc, randDone;

    rst_n = 1'b0;
    in_valid = 1'b0;
    inA = '0;
    inB = '0;
    inBin = 1'b0;
    out_ready = 1'b0;

    #12;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_D", {15'd0, D}, 64'd0);
    checkOutput("rst_bout", {63'd0, bout}, 64'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    $display("[TB] single op latency");
    @(posedge clk);
    #1;
    inA = 49'h1_0000_0000_0000;
    inB = 49'd1;
    inBin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'd3);
    checkOutput("single_D", {15'd0, D}, 64'h0_FFFF_FFFF_FFFF);
    checkOutput("single_bout", {63'd0, bout}, 64'd0);
    waitDrain("drain_single");

    $display("[TB] boundary cases");
    x = rand49();
    applyStimulus(x, x, 1'b0);
    applyStimulus('0, '0, 1'b1);
    applyStimulus({49{1'b1}}, '0, 1'b0);
    applyStimulus(49'd5, 49'd7, 1'b0);
    applyStimulus({49{1'b1}}, {49{1'b1}}, 1'b1);
    in_valid = 1'b0;
    waitDrain("drain_boundary");

    $display("[TB] streaming 1000 ops");
    startRet = retireCount;
    for (int i = 0; i < 1000; i++) applyStimulus(rand49(), rand49(), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("stream_count", 64'(retireCount - startRet), 64'd1000);
    waitDrain("drain_stream");

    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) ops[i] = rand49();
    firstExp = model(ops[0], ops[4], 1'b0);
    out_ready = 1'b0;
    startAcc = acceptCount;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      inA = ops[k];
      inB = ops[4];
      inBin = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (out_valid) checkOutput("bp_D_stable", {15'd0, D}, {15'd0, firstExp.d});
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    checkOutput("bp_accepted", 64'(acceptCount - startAcc), 64'd3);
    checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    applyStimulus(ops[3], ops[4], 1'b0);
    applyStimulus(ops[4], ops[4], 1'b0);
    in_valid = 1'b0;
    waitDrain("drain_bp");

    $display("[TB] reset mid-flight");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(rand49(), rand49(), 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("midrst_D", {15'd0, D}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    startRet = retireCount;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst_no_output", 64'(retireCount - startRet), 64'd0);

    $display("[TB] random valid/ready");
    startAcc = acceptCount;
    startRet = retireCount;
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          applyStimulus(rand49(), rand49(), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            inA = rand49();
            inB = rand49();
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    waitDrain("drain_random");
    checkOutput("random_accepted", 64'(acceptCount - startAcc), 64'd300);
    checkOutput("random_retired", 64'(retireCount - startRet), 64'd300);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
